// File: rtl/hw_sw_mailbox.sv
// Multi-channel SW->HW mailbox: per-channel request/ack FSMs feed a round-robin
// arbiter that pushes channel-tagged messages into one shared FIFO.
module hw_sw_mailbox #(
    parameter  int NUM_CH  = 4,
    parameter  int DATA_W  = 16,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*NUM_CH-1:0]      to_hw_sig,
    input  logic [DATA_W*NUM_CH-1:0] to_hw_data,
    output logic [2*NUM_CH-1:0]      to_sw_sig,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic [DATA_W-1:0]        msg_data,
    output logic [CH_W-1:0]          msg_ch,
    output logic [CNT_W-1:0]         fifo_count,
    output logic [NUM_CH-1:0]        err_flags,
    input  logic [NUM_CH-1:0]        err_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PEND,
        S_ACKED,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t            r_state [NUM_CH];
    state_t            w_next  [NUM_CH];
    logic [TMO_W-1:0]  r_tcnt  [NUM_CH];
    logic [1:0]        w_sig   [NUM_CH];
    logic [DATA_W-1:0] w_data  [NUM_CH];
    logic [NUM_CH-1:0] w_tmo;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_set_err;
    logic [NUM_CH-1:0] r_err;

    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_grant_ch;
    logic              w_grant_vld;
    logic              w_pop;
    logic              w_push_ok;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [CH_W-1:0]   r_mem_ch   [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_sig[k]  = to_hw_sig[2*k +: 2];
        assign w_data[k] = to_hw_data[DATA_W*k +: DATA_W];
        // An illegal code on a pending channel withdraws it from arbitration.
        assign w_req[k]  = (r_state[k] == S_PEND) && (w_sig[k] != 2'b11);
        if (TIMEOUT > 0) begin : g_tmo
            assign w_tmo[k] = (r_tcnt[k] == TMO_W'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_tmo[k] = 1'b0;
        end
    end

    always_comb begin
        w_pop       = msg_ready && (r_count != '0);
        w_push_ok   = (r_count != CNT_W'(DEPTH)) || w_pop;
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (!w_grant_vld && w_push_ok && w_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_state[k] <= S_WAIT;
                r_tcnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_state[k] <= w_next[k];
                if (((r_state[k] == S_ACKED) || (r_state[k] == S_DRAIN)) && (w_next[k] == r_state[k]))
                    r_tcnt[k] <= r_tcnt[k] + TMO_W'(1);
                else
                    r_tcnt[k] <= '0;
            end
        end
    end

    always_comb begin
        w_set_err = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_next[k] = r_state[k];
            if ((w_sig[k] == 2'b11) && (r_state[k] != S_ERR)) begin
                w_next[k]    = S_ERR;
                w_set_err[k] = 1'b1;
            end else begin
                case (r_state[k])
                    S_WAIT:  if (w_sig[k] == 2'b10) w_next[k] = S_PEND;
                    S_PEND:  if (w_grant_vld && (w_grant_ch == CH_W'(k))) w_next[k] = S_ACKED;
                    S_ACKED: begin
                        if (w_sig[k] == 2'b01) begin
                            w_next[k] = S_DRAIN;
                        end else if (w_tmo[k]) begin
                            w_next[k]    = S_ERR;
                            w_set_err[k] = 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (w_sig[k] == 2'b00) begin
                            w_next[k] = S_WAIT;
                        end else if (w_tmo[k]) begin
                            w_next[k]    = S_ERR;
                            w_set_err[k] = 1'b1;
                        end
                    end
                    S_ERR:   if (w_sig[k] == 2'b00) w_next[k] = S_WAIT;
                    default: w_next[k] = S_WAIT;
                endcase
            end
        end
    end

    always_comb begin
        to_sw_sig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (r_state[k])
                S_PEND:  to_sw_sig[2*k +: 2] = 2'b01;
                S_ACKED: to_sw_sig[2*k +: 2] = 2'b10;
                S_ERR:   to_sw_sig[2*k +: 2] = 2'b11;
                default: to_sw_sig[2*k +: 2] = 2'b00;
            endcase
        end
    end

    // A new error in the same cycle wins over a software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= '0;
        else
            r_err <= w_set_err | (r_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            if (w_grant_ch == CH_W'(NUM_CH - 1))
                r_rr_ptr <= '0;
            else
                r_rr_ptr <= w_grant_ch + CH_W'(1);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_grant_vld) begin
            r_mem_data[r_wptr] <= w_data[w_grant_ch];
            r_mem_ch[r_wptr]   <= w_grant_ch;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_grant_vld)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_grant_vld, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign msg_valid  = (r_count != '0);
    assign msg_data   = r_mem_data[r_rptr];
    assign msg_ch     = r_mem_ch[r_rptr];
    assign fifo_count = r_count;
    assign err_flags  = r_err;

endmodule

// File: tb/tb_hw_sw_mailbox.sv
// Self-checking bench for hw_sw_mailbox: directed scenarios plus random traffic,
// all compared each cycle against a queue-based behavioural model.
module tb_hw_sw_mailbox;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int DEP = 8;
    localparam int TMO = 16;
    localparam int CHW = 2;

    localparam int WAIT  = 0;
    localparam int PEND  = 1;
    localparam int ACKED = 2;
    localparam int DRAIN = 3;
    localparam int ERR   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2*NCH-1:0]  to_hw_sig = '0;
    logic [DW*NCH-1:0] to_hw_data = '0;
    logic [2*NCH-1:0]  to_sw_sig;
    logic              msg_valid;
    logic              msg_ready = 1'b0;
    logic [DW-1:0]     msg_data;
    logic [CHW-1:0]    msg_ch;
    logic [3:0]        fifo_count;
    logic [NCH-1:0]    err_flags;
    logic [NCH-1:0]    err_clr = '0;

    always #5 clk = ~clk;

    hw_sw_mailbox #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .DEPTH  (DEP),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .to_hw_sig (to_hw_sig),
        .to_hw_data(to_hw_data),
        .to_sw_sig (to_sw_sig),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .msg_ch    (msg_ch),
        .fifo_count(fifo_count),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus the software side presents this cycle.
    logic [1:0]     sig [NCH];
    logic [DW-1:0]  dat [NCH];
    logic           rdy;
    logic [NCH-1:0] clr;

    // Behavioural model: channel phases, cycles spent in phase, FIFO as queues.
    int             phase [NCH];
    int             age   [NCH];
    int             ptr;
    int             qCh [$];
    logic [DW-1:0]  qData [$];
    logic [NCH-1:0] mErr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] codeOf(input int ph);
        case (ph)
            PEND:    return 2'd1;
            ACKED:   return 2'd2;
            ERR:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NCH; k++) begin
            phase[k] = WAIT;
            age[k]   = 0;
        end
        ptr = 0;
        qCh.delete();
        qData.delete();
        mErr = '0;
    endtask

    task automatic modelStep();
        bit pop;
        bit setErr;
        int grant;
        int np;
        int na;
        int k;
        pop   = rdy && (qCh.size() > 0);
        grant = -1;
        if (qCh.size() < DEP || pop) begin
            for (int i = 0; i < NCH; i++) begin
                k = (ptr + i) % NCH;
                if (grant < 0 && phase[k] == PEND && sig[k] != 2'd3)
                    grant = k;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            setErr = 0;
            np     = phase[c];
            na     = age[c] + 1;
            if (sig[c] == 2'd3 && phase[c] != ERR) begin
                np     = ERR;
                setErr = 1;
            end else begin
                case (phase[c])
                    WAIT: if (sig[c] == 2'd2) np = PEND;
                    PEND: if (grant == c) np = ACKED;
                    ACKED, DRAIN: begin
                        if (phase[c] == ACKED && sig[c] == 2'd1) np = DRAIN;
                        else if (phase[c] == DRAIN && sig[c] == 2'd0) np = WAIT;
                        else if (age[c] + 1 >= TMO) begin
                            np     = ERR;
                            setErr = 1;
                        end
                    end
                    ERR: if (sig[c] == 2'd0) np = WAIT;
                    default: np = WAIT;
                endcase
            end
            if (np != phase[c]) na = 0;
            phase[c] = np;
            age[c]   = na;
            if (setErr) mErr[c] = 1'b1;
            else if (clr[c]) mErr[c] = 1'b0;
        end
        if (pop) begin
            void'(qCh.pop_front());
            void'(qData.pop_front());
        end
        if (grant >= 0) begin
            qCh.push_back(grant);
            qData.push_back(dat[grant]);
            ptr = (grant + 1) % NCH;
        end
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < NCH; k++) begin
            to_hw_sig[2*k +: 2]   = sig[k];
            to_hw_data[DW*k +: DW] = dat[k];
        end
        msg_ready = rdy;
        err_clr   = clr;
    endtask

    task automatic checkOutput();
        for (int k = 0; k < NCH; k++)
            chk($sformatf("to_sw_sig ch%0d", k), 32'(to_sw_sig[2*k +: 2]), 32'(codeOf(phase[k])));
        chk("msg_valid", 32'(msg_valid), 32'(qCh.size() > 0));
        chk("fifo_count", 32'(fifo_count), 32'(qCh.size()));
        if (qCh.size() > 0) begin
            chk("msg_data", 32'(msg_data), 32'(qData[0]));
            chk("msg_ch", 32'(msg_ch), 32'(qCh[0]));
        end
        chk("err_flags", 32'(err_flags), 32'(mErr));
    endtask

    task automatic tick();
        applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleInputs();
        for (int k = 0; k < NCH; k++) begin
            sig[k] = 2'd0;
            dat[k] = '0;
        end
        rdy = 1'b0;
        clr = '0;
    endtask

    task automatic doReset();
        idleInputs();
        applyStimulus();
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Software agent that walks each channel through complete handshakes.
    task automatic agentDrive(inout int issued, input int limit);
        for (int k = 0; k < NCH; k++) begin
            case (phase[k])
                WAIT: begin
                    if (issued < limit) begin
                        sig[k] = 2'd2;
                        dat[k] = DW'($urandom);
                        issued++;
                    end else begin
                        sig[k] = 2'd0;
                    end
                end
                PEND:    sig[k] = 2'd2;
                ACKED:   sig[k] = 2'd1;
                default: sig[k] = 2'd0;
            endcase
        end
    endtask

    initial begin
        int issued;
        int hc;
        bit reached;
        int r;

        $display("[TB] reset state");
        idleInputs();
        #1;
        doReset();

        $display("[TB] single message");
        sig[0] = 2'd2;
        dat[0] = 16'hBEEF;
        rdy    = 1'b1;
        tick();
        chk("single pend", 32'(to_sw_sig[1:0]), 32'd1);
        tick();
        chk("single ack", 32'(to_sw_sig[1:0]), 32'd2);
        chk("single valid", 32'(msg_valid), 32'd1);
        chk("single data", 32'(msg_data), 32'hBEEF);
        chk("single ch", 32'(msg_ch), 32'd0);
        sig[0] = 2'd1;
        tick();
        chk("single drain", 32'(to_sw_sig[1:0]), 32'd0);
        sig[0] = 2'd0;
        tick();

        $display("[TB] round robin");
        doReset();
        for (int k = 0; k < NCH; k++) begin
            sig[k] = 2'd2;
            dat[k] = DW'(k);
        end
        tick();
        for (int n = 1; n <= NCH; n++) begin
            tick();
            chk("rr count", 32'(fifo_count), 32'(n));
        end
        rdy = 1'b1;
        for (int n = 0; n < NCH; n++) begin
            chk("rr head ch", 32'(msg_ch), 32'(n));
            chk("rr head data", 32'(msg_data), 32'(n));
            tick();
        end
        chk("rr empty", 32'(fifo_count), 32'd0);
        for (int k = 0; k < NCH; k++) sig[k] = 2'd1;
        tick();
        for (int k = 0; k < NCH; k++) sig[k] = 2'd0;
        tick();

        $display("[TB] full fifo");
        doReset();
        issued  = 0;
        reached = 0;
        hc      = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            agentDrive(issued, 9);
            tick();
            if (qCh.size() == DEP && issued == 9) begin
                for (int k = 0; k < NCH; k++) begin
                    if (phase[k] == PEND) begin
                        reached = 1;
                        hc      = k;
                    end
                end
            end
        end
        chk("full reached", 32'(reached), 32'd1);
        chk("full count", 32'(fifo_count), 32'd8);
        chk("full held", 32'(to_sw_sig[2*hc +: 2]), 32'd1);
        agentDrive(issued, 9);
        tick();
        chk("full still held", 32'(to_sw_sig[2*hc +: 2]), 32'd1);
        rdy = 1'b1;
        agentDrive(issued, 9);
        tick();
        chk("full swap count", 32'(fifo_count), 32'd8);
        chk("full swap ack", 32'(to_sw_sig[2*hc +: 2]), 32'd2);
        for (int c = 0; c < 12; c++) begin
            agentDrive(issued, 9);
            tick();
        end
        chk("full drained", 32'(fifo_count), 32'd0);

        $display("[TB] timeout");
        doReset();
        rdy    = 1'b1;
        sig[2] = 2'd2;
        dat[2] = 16'h1234;
        tick();
        tick();
        chk("tmo acked", 32'(to_sw_sig[5:4]), 32'd2);
        repeat (TMO - 1) tick();
        chk("tmo last acked", 32'(to_sw_sig[5:4]), 32'd2);
        tick();
        chk("tmo err code", 32'(to_sw_sig[5:4]), 32'd3);
        chk("tmo err flags", 32'(err_flags), 32'h4);
        sig[2] = 2'd0;
        tick();
        chk("tmo back idle", 32'(to_sw_sig[5:4]), 32'd0);
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        chk("tmo cleared", 32'(err_flags), 32'd0);

        $display("[TB] illegal code");
        doReset();
        sig[1] = 2'd2;
        dat[1] = 16'h5A5A;
        tick();
        chk("ill pend", 32'(to_sw_sig[3:2]), 32'd1);
        sig[1] = 2'd3;
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        chk("ill no push", 32'(fifo_count), 32'd0);
        chk("ill err code", 32'(to_sw_sig[3:2]), 32'd3);
        chk("ill flag kept", 32'(err_flags[1]), 32'd1);
        sig[1] = 2'd0;
        tick();
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;

        $display("[TB] async reset");
        doReset();
        for (int k = 0; k < 3; k++) begin
            sig[k] = 2'd2;
            dat[k] = DW'(16'hA0 + k);
        end
        repeat (4) tick();
        chk("ar queued", 32'(fifo_count), 32'd3);
        #3;
        reset = 1'b0;
        modelReset();
        #1;
        chk("ar valid", 32'(msg_valid), 32'd0);
        chk("ar count", 32'(fifo_count), 32'd0);
        chk("ar sigs", 32'(to_sw_sig), 32'd0);
        idleInputs();
        applyStimulus();
        @(posedge clk);
        #1;
        checkOutput();
        reset  = 1'b1;
        sig[3] = 2'd2;
        dat[3] = 16'hC0DE;
        tick();
        tick();
        chk("ar new ch", 32'(msg_ch), 32'd3);
        chk("ar new data", 32'(msg_data), 32'hC0DE);

        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NCH; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 4)       sig[k] = 2'd3;
                else if (r < 40) sig[k] = 2'd2;
                else if (r < 70) sig[k] = 2'd1;
                else             sig[k] = 2'd0;
                dat[k] = DW'($urandom);
                clr[k] = ($urandom_range(0, 9) == 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hw_sw_mailbox.md
Name: hw_sw_mailbox

Overview:
Multi-channel successor to the single-channel 2-bit hardware/software handshake. Each of NUM_CH software channels posts a DATA_W-bit message using a 2-bit request code. A per-channel FSM acknowledges the message, and a round-robin arbiter pushes accepted messages into one shared DEPTH-entry FIFO, tagged with the channel number, for the game logic to consume. Adds per-channel timeout, illegal-code detection and sticky error flags.

Parameters:
NUM_CH, 4, number of software channels (1..16)
DATA_W, 16, message payload width
DEPTH, 8, shared message FIFO depth (power of 2, >=2)
TIMEOUT, 1024, cycles allowed in ACKED/DRAIN before error; 0 disables
CH_W, max($clog2(NUM_CH),1), channel tag width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
to_hw_sig  in  2*NUM_CH  per-channel SW request code; channel k at bits [2k+1:2k]
to_hw_data  in  DATA_W*NUM_CH  per-channel payload; channel k at [DATA_W*(k+1)-1:DATA_W*k]
to_sw_sig  out  2*NUM_CH  per-channel HW status code
msg_valid  out  1  FIFO non-empty
msg_ready  in  1  consumer pops the head entry when msg_valid & msg_ready
msg_data  out  DATA_W  head payload
msg_ch  out  CH_W  head channel tag
fifo_count  out  $clog2(DEPTH)+1  current occupancy
err_flags  out  NUM_CH  sticky per-channel error
err_clr  in  NUM_CH  per-channel clear of err_flags, one-cycle pulse

Behaviour:
- All inputs are synchronous to clk; no synchronisers.
- Reset (async assert, sync release): all channel FSMs go to WAIT; to_sw_sig=0; FIFO empty; msg_valid=0; fifo_count=0; err_flags=0; arbiter pointer=0; timeout counters=0.
- SW codes: 0 idle, 2 request, 1 release, 3 illegal.
- HW codes: 0 idle, 1 pending, 2 acknowledged, 3 error.
- Channel FSM (state / to_sw_sig):
  - WAIT / 0: sig==2 -> PEND. sig==1 stays in WAIT.
  - PEND / 1: requests the arbiter. When granted -> ACKED. Payload is sampled from to_hw_data in the grant cycle.
  - ACKED / 2: sig==1 -> DRAIN.
  - DRAIN / 0: sig==0 -> WAIT.
  - ERR / 3: sig==0 -> WAIT.
- Illegal code: sig==3 in any non-ERR state -> ERR next cycle. It sets err_flags[k]. It overrides a grant in the same cycle: no push.
- Timeout: the counter clears on entry to ACKED or DRAIN and increments each cycle in those states. Reaching TIMEOUT -> ERR and sets err_flags[k]. PEND has no timeout; FIFO backpressure is legal.
- err_flags[k] set has priority over err_clr[k] in the same cycle.
- Arbiter: at most one push per cycle. Round-robin among channels in PEND, starting the search at the pointer. After a grant to channel g, the pointer = (g+1) mod NUM_CH. The pointer is unchanged when no grant is made.
- A grant is issued only when push is allowed: fifo_count<DEPTH, or fifo_count==DEPTH with a pop in the same cycle.
- FIFO:
  - Write and read pointers wrap mod DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - msg_data/msg_ch are registered head contents, valid whenever msg_valid=1.
  - A pushed entry is visible at msg_* on the next cycle when the FIFO was empty (1-cycle latency).
  - A pop while empty is ignored.
- Grant to to_sw_sig=2 latency: 1 cycle. Grant to msg_valid: 1 cycle when empty.
- Reset asserted mid-handshake discards FIFO contents and in-flight channel states immediately.

Test Plan:
- Single message: ch0 sig=2, data=16'hBEEF, msg_ready=1 -> to_sw_sig[1:0]=1 for 1 cycle, then 2. Next cycle msg_valid=1, msg_data=BEEF, msg_ch=0. Then sig=1 -> 0, sig=0 -> WAIT.
- Round-robin: all 4 channels assert sig=2 in the same cycle, data=k -> pushes in order ch0,1,2,3 on consecutive cycles. fifo_count rises 1..4. msg_ch pops 0,1,2,3.
- Full FIFO: msg_ready=0, 9 requests across channels with DEPTH=8 -> fifo_count=8 and the 9th channel holds code 1. Raise msg_ready for 1 cycle -> simultaneous pop+push, count stays 8, 9th channel goes to 2.
- Timeout: TIMEOUT=16, ch2 reaches ACKED and SW holds sig=2 -> after 16 cycles to_sw_sig[5:4]=3 and err_flags=4'b0100. sig=0 -> 0. err_clr[2] pulse -> err_flags=0.
- Illegal code: ch1 in PEND with a grant available, sig=3 -> no push, fifo_count unchanged, ERR, err_flags[1]=1. Same-cycle err_clr[1]=1 still leaves flag=1.
- Async reset: assert reset=0 mid-stream with 3 entries queued -> outputs clear immediately (msg_valid=0, fifo_count=0, all to_sw_sig=0). After release, a new request on ch3 returns msg_ch=3.
